permute_arbiter: RTL and testbench
==================================

// Module: permute_arbiter
// PURPOSE
// Shares one permute_stage (absorb/permute/squeeze engine) between N_REQ independent load/store channel pairs.
// Grants are message-granular: a requester owns the core from its first input block until the core reports its
// final output block written. Sits between the per-channel load stages and the permute stage (input side), and
// between the permute stage and the per-channel store stages (output side).
// PARAMETERS
// N_REQ    2               number of requester channels (>=2)
// RATE_W   RATE_SHAKE128   rate block width in bits
// MODE_W   2               operation_mode width
// SIZE_W   32              output_size width
// PORTS
// clk                         in   1             clock, all state on rising edge
// rst                         in   1             asynchronous reset, active-low
// req_rate_input              in   N_REQ*RATE_W  per-channel rate block; channel i at [i*RATE_W +: RATE_W]
// req_operation_mode          in   N_REQ*MODE_W  per-channel mode
// req_output_size             in   N_REQ*SIZE_W  per-channel output size
// req_input_buffer_ready      in   N_REQ         per-channel input block valid flag
// req_last_block_in_buffer    in   N_REQ         per-channel last-block flag
// req_input_buffer_ready_clr  out  N_REQ         routed clear, one-hot or zero
// req_last_block_clr          out  N_REQ         routed clear, one-hot or zero
// req_output_buffer_available in   N_REQ         per-channel store buffer free flag
// req_output_buffer_avail_clr out  N_REQ         routed clear, one-hot or zero
// req_output_buffer_we        out  N_REQ         routed write enable, one-hot or zero
// req_last_output_block_wr    out  N_REQ         routed final-block strobe, one-hot or zero
// ps_rate_input / ps_operation_mode / ps_output_size  out  RATE_W/MODE_W/SIZE_W  muxed to permute_stage
// ps_input_buffer_ready / ps_last_block_in_buffer / ps_output_buffer_available  out 1  muxed to permute_stage
// ps_input_buffer_ready_clr / ps_last_block_in_buffer_clr / ps_output_buffer_available_clr  in 1  from core
// ps_output_buffer_we / ps_last_output_block_wr      in  1  from permute_stage
// busy                        out  1             core owned
// grant_idx                   out  $clog2(N_REQ) current or last owner
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE, grant_idx=0, rr_ptr=0, busy=0. All ps_* valid flags and req_* strobes are 0.
// - FSM: IDLE -> BUSY when any req_input_buffer_ready=1. BUSY -> RELEASE on ps_last_output_block_wr=1.
//   RELEASE -> IDLE unconditionally, 1 cycle, so the core FSM settles back to idle.
// - Arbitration in IDLE is round-robin from rr_ptr: the lowest index >= rr_ptr wins, wrapping modulo N_REQ.
//   The winner is registered into grant_idx at the IDLE->BUSY edge.
// - On BUSY->RELEASE: rr_ptr <= (grant_idx+1) mod N_REQ.
// - Latency: request seen at edge t; ps_input_buffer_ready=1 from cycle t+1. Re-grant no earlier than 2 cycles
//   after the final-block strobe.
// - In BUSY, all ps_* data and flag outputs are combinational muxes from channel grant_idx.
//   Core clears/we/last strobes are demuxed one-hot to grant_idx, same cycle, no added latency.
// - In IDLE and RELEASE: ps_input_buffer_ready=0, ps_last_block_in_buffer=0, ps_output_buffer_available=0.
//   ps_rate_input etc. are still muxed from grant_idx (don't-care). All req_* strobes=0.
// - Core strobes arriving outside BUSY are ignored, not routed.
// - Non-owner channels never see a clear/we. Their ready flags stay pending and are arbitrated at next IDLE.
// - Owner dropping req_input_buffer_ready mid-message: grant held; core stalls on the flag as usual.
// - Final strobe and a new request in the same cycle: no grant until IDLE; the request is simply held.
// - Async reset mid-message aborts the grant immediately. permute_stage shares the reset, so no state survives.
// STRUCTURE
// - keccak_pkg: RATE_SHAKE128 (existing); add typedef enum logic[1:0] {ARB_IDLE, ARB_BUSY, ARB_RELEASE}
//   arb_state_t and localparam ARB_IDX_W helper function.
// - One sub-module: rr_arbiter (N_REQ, req vector, rr_ptr -> one-hot grant + index, combinational).
// - Top holds FSM, grant_idx, rr_ptr registers, mux/demux logic.
// TESTING
// 1 Reset with req_input_buffer_ready=2'b11 held: all outputs 0 while rst=0; first edge after release grants ch0.
// 2 Ch1 only requests, 3-block absorb, 2-block squeeze: clears/we appear only on bit1. Ch0 bits stay 0.
//   Owner released 1 cycle after last_output_block_wr, busy=0 on the following cycle.
// 3 Both request continuously for 4 messages: grant sequence 0,1,0,1; rr_ptr wraps 1->0.
// 4 Ch0 asserts ready mid-ch1 message: ch0 ready/clr untouched until ch1 RELEASE, then ch0 granted next IDLE edge.
// 5 Inject ps_output_buffer_we / ps_last_output_block_wr pulses in IDLE: no req_* strobe, state stays IDLE.
// 6 Drop rst during ch0 squeeze block 1: busy, grant-routed strobes and ps_input_buffer_ready go 0
//   asynchronously; after release, pending ch1 is granted per rr_ptr=0 order.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared constants and types for the Keccak datapath blocks.
// The permute arbiter takes its FSM state type and index-width helper from here.
package keccak_pkg;

  localparam int unsigned RATE_SHAKE128 = 1344;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_RELEASE
  } arb_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned arb_idx_w(input int unsigned n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/permute_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the lowest requesting index at or above rr_ptr wins,
// wrapping to the low indices when nothing at or above the pointer is requesting.
module rr_arbiter import keccak_pkg::*; #(
  parameter int unsigned N_REQ = 2,
  localparam int unsigned IdxW = arb_idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IdxW-1:0]  rr_ptr,
  output logic [N_REQ-1:0] grant_oh,
  output logic [IdxW-1:0]  grant_idx,
  output logic             any_req
);

  logic found;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    // Upper pass: rr_ptr .. N_REQ-1.
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req[i] && (i >= 32'(rr_ptr))) begin
        found       = 1'b1;
        grant_oh[i] = 1'b1;
        grant_idx   = IdxW'(i);
      end
    end
    // Wrap pass: indices below rr_ptr.
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req[i]) begin
        found       = 1'b1;
        grant_oh[i] = 1'b1;
        grant_idx   = IdxW'(i);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/permute_arbiter.sv
// Shares one permute_stage between N_REQ load/store channel pairs with message-granular grants:
// an owner keeps the core from its first input block until the core writes its final output block.
module permute_arbiter import keccak_pkg::*; #(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned RATE_W = RATE_SHAKE128,
  parameter int unsigned MODE_W = 2,
  parameter int unsigned SIZE_W = 32,
  localparam int unsigned IdxW  = arb_idx_w(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [N_REQ*RATE_W-1:0] req_rate_input,
  input  logic [N_REQ*MODE_W-1:0] req_operation_mode,
  input  logic [N_REQ*SIZE_W-1:0] req_output_size,
  input  logic [N_REQ-1:0]        req_input_buffer_ready,
  input  logic [N_REQ-1:0]        req_last_block_in_buffer,
  output logic [N_REQ-1:0]        req_input_buffer_ready_clr,
  output logic [N_REQ-1:0]        req_last_block_clr,
  input  logic [N_REQ-1:0]        req_output_buffer_available,
  output logic [N_REQ-1:0]        req_output_buffer_avail_clr,
  output logic [N_REQ-1:0]        req_output_buffer_we,
  output logic [N_REQ-1:0]        req_last_output_block_wr,

  output logic [RATE_W-1:0]       ps_rate_input,
  output logic [MODE_W-1:0]       ps_operation_mode,
  output logic [SIZE_W-1:0]       ps_output_size,
  output logic                    ps_input_buffer_ready,
  output logic                    ps_last_block_in_buffer,
  output logic                    ps_output_buffer_available,
  input  logic                    ps_input_buffer_ready_clr,
  input  logic                    ps_last_block_in_buffer_clr,
  input  logic                    ps_output_buffer_available_clr,
  input  logic                    ps_output_buffer_we,
  input  logic                    ps_last_output_block_wr,

  output logic                    busy,
  output logic [IdxW-1:0]         grant_idx
);

  arb_state_t       state_q, state_d;
  logic [IdxW-1:0]  grant_idx_q, grant_idx_d;
  logic [N_REQ-1:0] grant_oh_q, grant_oh_d;
  logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;

  logic [N_REQ-1:0] arb_oh;
  logic [IdxW-1:0]  arb_idx;
  logic             arb_any;
  logic             owned;

  logic             sel_ready;
  logic             sel_last;
  logic             sel_avail;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .req       (req_input_buffer_ready),
    .rr_ptr    (rr_ptr_q),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      grant_idx_q <= '0;
      grant_oh_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      grant_oh_q  <= grant_oh_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    grant_oh_d  = grant_oh_q;
    rr_ptr_d    = rr_ptr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (arb_any) begin
          state_d     = ARB_BUSY;
          grant_idx_d = arb_idx;
          grant_oh_d  = arb_oh;
        end
      end
      ARB_BUSY: begin
        if (ps_last_output_block_wr) begin
          state_d  = ARB_RELEASE;
          rr_ptr_d = (grant_idx_q == IdxW'(N_REQ - 1)) ? '0 : grant_idx_q + 1'b1;
        end
      end
      // One dead cycle lets the core FSM settle back to idle before the next grant.
      ARB_RELEASE: state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  // Data paths follow grant_idx in every state; only the valid flags are gated by ownership.
  always_comb begin
    ps_rate_input     = '0;
    ps_operation_mode = '0;
    ps_output_size    = '0;
    sel_ready         = 1'b0;
    sel_last          = 1'b0;
    sel_avail         = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_idx_q == IdxW'(i)) begin
        ps_rate_input     = req_rate_input[i*RATE_W +: RATE_W];
        ps_operation_mode = req_operation_mode[i*MODE_W +: MODE_W];
        ps_output_size    = req_output_size[i*SIZE_W +: SIZE_W];
        sel_ready         = req_input_buffer_ready[i];
        sel_last          = req_last_block_in_buffer[i];
        sel_avail         = req_output_buffer_available[i];
      end
    end
  end

  assign owned = (state_q == ARB_BUSY);

  assign ps_input_buffer_ready      = owned & sel_ready;
  assign ps_last_block_in_buffer    = owned & sel_last;
  assign ps_output_buffer_available = owned & sel_avail;

  // Core strobes outside BUSY are dropped rather than routed.
  assign req_input_buffer_ready_clr  = {N_REQ{owned & ps_input_buffer_ready_clr}} & grant_oh_q;
  assign req_last_block_clr          = {N_REQ{owned & ps_last_block_in_buffer_clr}} & grant_oh_q;
  assign req_output_buffer_avail_clr = {N_REQ{owned & ps_output_buffer_available_clr}} & grant_oh_q;
  assign req_output_buffer_we        = {N_REQ{owned & ps_output_buffer_we}} & grant_oh_q;
  assign req_last_output_block_wr    = {N_REQ{owned & ps_last_output_block_wr}} & grant_oh_q;

  assign busy      = owned;
  assign grant_idx = grant_idx_q;

endmodule

// File: tb/tb_permute_arbiter.sv
// Bench for permute_arbiter: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against a message-level ownership model.
module tb_permute_arbiter;
  import keccak_pkg::*;

  localparam int unsigned N  = 2;
  localparam int unsigned RW = 64;
  localparam int unsigned MW = 2;
  localparam int unsigned SW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*RW-1:0] req_rate_input;
  logic [N*MW-1:0] req_operation_mode;
  logic [N*SW-1:0] req_output_size;
  logic [N-1:0]  req_input_buffer_ready;
  logic [N-1:0]  req_last_block_in_buffer;
  logic [N-1:0]  req_input_buffer_ready_clr;
  logic [N-1:0]  req_last_block_clr;
  logic [N-1:0]  req_output_buffer_available;
  logic [N-1:0]  req_output_buffer_avail_clr;
  logic [N-1:0]  req_output_buffer_we;
  logic [N-1:0]  req_last_output_block_wr;
  logic [RW-1:0] ps_rate_input;
  logic [MW-1:0] ps_operation_mode;
  logic [SW-1:0] ps_output_size;
  logic          ps_input_buffer_ready;
  logic          ps_last_block_in_buffer;
  logic          ps_output_buffer_available;
  logic          ps_input_buffer_ready_clr;
  logic          ps_last_block_in_buffer_clr;
  logic          ps_output_buffer_available_clr;
  logic          ps_output_buffer_we;
  logic          ps_last_output_block_wr;
  logic          busy;
  logic [0:0]    grant_idx;

  int errors = 0;
  int checks = 0;

  permute_arbiter #(
    .N_REQ  (N),
    .RATE_W (RW),
    .MODE_W (MW),
    .SIZE_W (SW)
  ) dut (
    .clk                            (clk),
    .rst                            (rst),
    .req_rate_input                 (req_rate_input),
    .req_operation_mode             (req_operation_mode),
    .req_output_size                (req_output_size),
    .req_input_buffer_ready         (req_input_buffer_ready),
    .req_last_block_in_buffer       (req_last_block_in_buffer),
    .req_input_buffer_ready_clr     (req_input_buffer_ready_clr),
    .req_last_block_clr             (req_last_block_clr),
    .req_output_buffer_available    (req_output_buffer_available),
    .req_output_buffer_avail_clr    (req_output_buffer_avail_clr),
    .req_output_buffer_we           (req_output_buffer_we),
    .req_last_output_block_wr       (req_last_output_block_wr),
    .ps_rate_input                  (ps_rate_input),
    .ps_operation_mode              (ps_operation_mode),
    .ps_output_size                 (ps_output_size),
    .ps_input_buffer_ready          (ps_input_buffer_ready),
    .ps_last_block_in_buffer        (ps_last_block_in_buffer),
    .ps_output_buffer_available     (ps_output_buffer_available),
    .ps_input_buffer_ready_clr      (ps_input_buffer_ready_clr),
    .ps_last_block_in_buffer_clr    (ps_last_block_in_buffer_clr),
    .ps_output_buffer_available_clr (ps_output_buffer_available_clr),
    .ps_output_buffer_we            (ps_output_buffer_we),
    .ps_last_output_block_wr        (ps_last_output_block_wr),
    .busy                           (busy),
    .grant_idx                      (grant_idx)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: who owns the core, whether a message is in flight, and the fairness pointer.
  int m_owned   = 0;  // 1 while a message holds the core
  int m_cooling = 0;  // 1 for the single dead cycle after a final block
  int m_owner   = 0;
  int m_ptr     = 0;

  function automatic int pick(input logic [N-1:0] r, input int ptr);
    int w = -1;
    for (int k = 0; k < N; k++) begin
      if (w < 0 && r[(ptr + k) % N]) w = (ptr + k) % N;
    end
    return w;
  endfunction

  function automatic logic [N-1:0] oh_of(input int i);
    logic [N-1:0] v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owned   <= 0;
      m_cooling <= 0;
      m_owner   <= 0;
      m_ptr     <= 0;
    end else if (m_owned == 1) begin
      if (ps_last_output_block_wr) begin
        m_owned   <= 0;
        m_cooling <= 1;
        m_ptr     <= (m_owner + 1) % N;
      end
    end else if (m_cooling == 1) begin
      m_cooling <= 0;
    end else if (req_input_buffer_ready != '0) begin
      m_owned <= 1;
      m_owner <= pick(req_input_buffer_ready, m_ptr);
    end
  end

  always @(negedge clk) begin
    logic         own;
    logic [N-1:0] oh;
    own = (m_owned == 1);
    oh  = own ? oh_of(m_owner) : '0;
    chk("busy", busy, own);
    chk("grant_idx", grant_idx, 64'(m_owner));
    chk("ps_rate", ps_rate_input, req_rate_input[m_owner*RW +: RW]);
    chk("ps_mode", ps_operation_mode, req_operation_mode[m_owner*MW +: MW]);
    chk("ps_size", ps_output_size, req_output_size[m_owner*SW +: SW]);
    chk("ps_rdy", ps_input_buffer_ready, own & req_input_buffer_ready[m_owner]);
    chk("ps_last", ps_last_block_in_buffer, own & req_last_block_in_buffer[m_owner]);
    chk("ps_avail", ps_output_buffer_available, own & req_output_buffer_available[m_owner]);
    chk("rdy_clr", req_input_buffer_ready_clr, ps_input_buffer_ready_clr ? oh : '0);
    chk("last_clr", req_last_block_clr, ps_last_block_in_buffer_clr ? oh : '0);
    chk("avail_clr", req_output_buffer_avail_clr, ps_output_buffer_available_clr ? oh : '0);
    chk("we", req_output_buffer_we, ps_output_buffer_we ? oh : '0);
    chk("last_wr", req_last_output_block_wr, ps_last_output_block_wr ? oh : '0);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < (N * RW) / 32; i++) req_rate_input[i*32 +: 32] = $urandom;
    req_operation_mode          = MW'($urandom);
    req_output_size             = {$urandom, $urandom};
    req_last_block_in_buffer    = N'($urandom);
    req_output_buffer_available = N'($urandom);
  endtask

  task automatic clear_strobes();
    ps_input_buffer_ready_clr      = 1'b0;
    ps_last_block_in_buffer_clr    = 1'b0;
    ps_output_buffer_available_clr = 1'b0;
    ps_output_buffer_we            = 1'b0;
    ps_last_output_block_wr        = 1'b0;
  endtask

  task automatic finish_msg();
    cyc(); ps_last_output_block_wr = 1'b1;
    cyc(); ps_last_output_block_wr = 1'b0;
    cyc();
  endtask

  initial begin
    int c;
    rst = 1'b1;
    req_input_buffer_ready = '0;
    clear_strobes();
    randomize_data();
    #1 rst = 1'b0;

    // 1: reset held with both requesting, then ch0 wins the first edge.
    req_input_buffer_ready = 2'b11;
    repeat (3) begin
      @(negedge clk);
      chk("t1_rst_busy", busy, 0);
      chk("t1_rst_psrdy", ps_input_buffer_ready, 0);
    end
    cyc(); rst = 1'b1;
    cyc();
    @(negedge clk);
    chk("t1_busy", busy, 1);
    chk("t1_grant", grant_idx, 0);
    cyc(); req_input_buffer_ready = '0;
    finish_msg();

    // 2: ch1 alone, three absorb blocks then two squeeze blocks.
    req_input_buffer_ready = 2'b10;
    cyc();
    @(negedge clk);
    chk("t2_grant", grant_idx, 1);
    chk("t2_psrdy", ps_input_buffer_ready, 1);
    for (int b = 0; b < 3; b++) begin
      cyc();
      ps_input_buffer_ready_clr   = 1'b1;
      ps_last_block_in_buffer_clr = (b == 2);
      if (b == 2) req_input_buffer_ready = '0;
      @(negedge clk);
      chk("t2_rdy_clr", req_input_buffer_ready_clr, 2'b10);
      chk("t2_last_clr", req_last_block_clr, (b == 2) ? 2'b10 : 2'b00);
    end
    for (int b = 0; b < 2; b++) begin
      cyc();
      ps_input_buffer_ready_clr      = 1'b0;
      ps_last_block_in_buffer_clr    = 1'b0;
      ps_output_buffer_we            = 1'b1;
      ps_output_buffer_available_clr = 1'b1;
      ps_last_output_block_wr        = (b == 1);
      @(negedge clk);
      chk("t2_we", req_output_buffer_we, 2'b10);
      chk("t2_last_wr", req_last_output_block_wr, (b == 1) ? 2'b10 : 2'b00);
    end
    cyc();
    ps_output_buffer_available_clr = 1'b0;
    ps_last_output_block_wr        = 1'b0;
    @(negedge clk);
    chk("t2_released", busy, 0);
    chk("t2_we_release", req_output_buffer_we, 2'b00);
    cyc(); ps_output_buffer_we = 1'b0;

    // 3: both request continuously; grants alternate starting at ch0.
    req_input_buffer_ready = 2'b11;
    for (int m = 0; m < 4; m++) begin
      c = 0;
      @(negedge clk);
      while (!busy && c < 8) begin
        @(negedge clk);
        c++;
      end
      if (!busy) chk("t3_timeout", busy, 1);
      chk("t3_grant_seq", grant_idx, 64'(m % 2));
      cyc(); ps_last_output_block_wr = 1'b1;
      cyc(); ps_last_output_block_wr = 1'b0;
    end
    req_input_buffer_ready = '0;
    cyc();

    // 4: ch0 raises ready during a ch1 message; it waits for the release.
    req_input_buffer_ready = 2'b10;
    cyc();
    req_input_buffer_ready = 2'b11;
    @(negedge clk);
    chk("t4_grant1", grant_idx, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(); ps_input_buffer_ready_clr = 1'b1;
      @(negedge clk);
      chk("t4_ch0_untouched", req_input_buffer_ready_clr, 2'b10);
    end
    cyc();
    ps_input_buffer_ready_clr = 1'b0;
    ps_last_output_block_wr   = 1'b1;
    req_input_buffer_ready    = 2'b01;
    @(negedge clk);
    chk("t4_busy_final", busy, 1);
    cyc(); ps_last_output_block_wr = 1'b0;
    @(negedge clk);
    chk("t4_release", busy, 0);
    cyc();
    @(negedge clk);
    chk("t4_idle", busy, 0);
    cyc();
    @(negedge clk);
    chk("t4_busy0", busy, 1);
    chk("t4_grant0", grant_idx, 0);

    // 5: core strobes while idle are not routed and do not move the FSM.
    cyc(); req_input_buffer_ready = '0; ps_last_output_block_wr = 1'b1;
    cyc(); ps_last_output_block_wr = 1'b0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      ps_output_buffer_we            = 1'b1;
      ps_last_output_block_wr        = 1'b1;
      ps_output_buffer_available_clr = 1'b1;
      @(negedge clk);
      chk("t5_we", req_output_buffer_we, 2'b00);
      chk("t5_last_wr", req_last_output_block_wr, 2'b00);
      chk("t5_idle", busy, 0);
      cyc();
    end
    clear_strobes();
    @(negedge clk);
    chk("t5_still_idle", busy, 0);

    // 6: reset mid-squeeze aborts at once; pending ch1 then wins from pointer 0.
    cyc(); req_input_buffer_ready = 2'b01;
    cyc();
    req_input_buffer_ready         = 2'b11;
    ps_output_buffer_we            = 1'b1;
    ps_output_buffer_available_clr = 1'b1;
    #1;
    chk("t6_pre_busy", busy, 1);
    chk("t6_pre_we", req_output_buffer_we, 2'b01);
    #1 rst = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_we", req_output_buffer_we, 2'b00);
    chk("t6_avail_clr", req_output_buffer_avail_clr, 2'b00);
    chk("t6_psrdy", ps_input_buffer_ready, 0);
    req_input_buffer_ready = 2'b10;
    clear_strobes();
    cyc(); rst = 1'b1;
    @(negedge clk);
    chk("t6_idle", busy, 0);
    cyc();
    @(negedge clk);
    chk("t6_busy1", busy, 1);
    chk("t6_grant1", grant_idx, 1);
    cyc(); req_input_buffer_ready = '0;
    finish_msg();

    // Random traffic, occasional asynchronous resets.
    for (int n = 0; n < 2000; n++) begin
      cyc();
      randomize_data();
      for (int i = 0; i < N; i++) req_input_buffer_ready[i] = ($urandom_range(0, 3) != 0);
      ps_input_buffer_ready_clr      = $urandom_range(0, 1) == 1;
      ps_last_block_in_buffer_clr    = $urandom_range(0, 3) == 0;
      ps_output_buffer_available_clr = $urandom_range(0, 1) == 1;
      ps_output_buffer_we            = $urandom_range(0, 1) == 1;
      ps_last_output_block_wr        = $urandom_range(0, 7) == 0;
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
